// File: rtl/pipeline_spi_layer_control_pkg.sv
// Shared opcodes, FSM states and decode helpers for the multi-layer SPI overlay control block.
package pipeline_spi_layer_control_pkg;

    localparam logic [7:0] OP_RESET  = 8'h00;
    localparam logic [7:0] OP_MODE   = 8'h01;
    localparam logic [7:0] OP_FLAGS  = 8'h02;
    localparam logic [7:0] OP_SCALE  = 8'h03;
    localparam logic [7:0] OP_OFFX   = 8'h04;
    localparam logic [7:0] OP_OFFY   = 8'h05;
    localparam logic [7:0] OP_TRANSP = 8'h06;
    localparam logic [7:0] OP_CLIP_L = 8'h07;
    localparam logic [7:0] OP_CLIP_R = 8'h08;
    localparam logic [7:0] OP_CLIP_T = 8'h09;
    localparam logic [7:0] OP_CLIP_B = 8'h0A;
    localparam logic [7:0] OP_FREEZE = 8'h0B;
    localparam logic [7:0] OP_IMAGE  = 8'h0C;
    localparam logic [7:0] OP_FILTER = 8'h0E;
    localparam logic [7:0] OP_COMMIT = 8'h10;
    localparam logic [7:0] OP_NOP    = 8'hFF;

    localparam logic [15:0] FILTER_RESET = 16'h258C;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAYER    = 3'd1,
        ST_ARG1     = 3'd2,
        ST_ARG2     = 3'd3,
        ST_APPLY    = 3'd4,
        ST_PASSTHRU = 3'd5
    } state_e;

    function automatic logic is_layer_op(input logic [7:0] op);
        return (op >= OP_MODE) && (op <= OP_FREEZE);
    endfunction

    function automatic logic is_known_op(input logic [7:0] op);
        return is_layer_op(op) || (op == OP_RESET) || (op == OP_FILTER) ||
               (op == OP_COMMIT) || (op == OP_IMAGE) || (op == OP_NOP);
    endfunction

    function automatic logic [1:0] arg_count(input logic [7:0] op);
        case (op)
            OP_MODE, OP_FLAGS, OP_SCALE, OP_TRANSP, OP_FREEZE:            return 2'd1;
            OP_OFFX, OP_OFFY, OP_CLIP_L, OP_CLIP_R, OP_CLIP_T, OP_CLIP_B,
            OP_FILTER:                                                    return 2'd2;
            default:                                                      return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_spi_layer_control_regs.sv
// One foreground layer's shadow and live control registers; live copies shadow on commit.
module pipeline_spi_layer_control_regs
    import pipeline_spi_layer_control_pkg::*;
#(
    parameter int PRECISION              = 11,
    parameter int TRANSPARENCY_PRECISION = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [7:0]                          wr_op,
    input  logic [15:0]                         wr_data,
    input  logic                                clear,
    input  logic                                commit,
    output logic [1:0]                          live_mode,
    output logic [1:0]                          live_scale,
    output logic [PRECISION:0]                  live_offset_x,
    output logic [PRECISION:0]                  live_offset_y,
    output logic [4*PRECISION-1:0]              live_clip,
    output logic [TRANSPARENCY_PRECISION-1:0]   live_transparency,
    output logic                                live_freeze
);
    localparam int P = PRECISION;
    localparam int T = TRANSPARENCY_PRECISION;

    logic [1:0]     mode_r;
    logic [1:0]     scale_r;
    logic [P:0]     offset_x_r;
    logic [P:0]     offset_y_r;
    logic [4*P-1:0] clip_r;
    logic [T-1:0]   transparency_r;
    logic           freeze_r;
    logic           unused_data_s;

    assign unused_data_s = ^wr_data[15:P+1];

    // shadow bank: field write truncates to the field width; FLAGS lands in default and is dropped
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mode_r         <= 2'd0;
            scale_r        <= 2'd0;
            offset_x_r     <= '0;
            offset_y_r     <= '0;
            clip_r         <= '0;
            transparency_r <= '0;
            freeze_r       <= 1'b0;
        end else if (wr_en) begin
            case (wr_op)
                OP_MODE:   mode_r               <= wr_data[1:0];
                OP_SCALE:  scale_r              <= wr_data[1:0];
                OP_OFFX:   offset_x_r           <= wr_data[P:0];
                OP_OFFY:   offset_y_r           <= wr_data[P:0];
                OP_CLIP_L: clip_r[0*P +: P]     <= wr_data[P-1:0];
                OP_CLIP_R: clip_r[1*P +: P]     <= wr_data[P-1:0];
                OP_CLIP_T: clip_r[2*P +: P]     <= wr_data[P-1:0];
                OP_CLIP_B: clip_r[3*P +: P]     <= wr_data[P-1:0];
                OP_TRANSP: transparency_r       <= wr_data[T-1:0];
                OP_FREEZE: freeze_r             <= wr_data[0];
                default:   ;
            endcase
        end
    end

    // live bank: takes the pre-write shadow value when a write coincides with commit
    always_ff @(posedge clk) begin
        if (rst) begin
            live_mode         <= 2'd0;
            live_scale        <= 2'd0;
            live_offset_x     <= '0;
            live_offset_y     <= '0;
            live_clip         <= '0;
            live_transparency <= '0;
            live_freeze       <= 1'b0;
        end else if (commit) begin
            live_mode         <= mode_r;
            live_scale        <= scale_r;
            live_offset_x     <= offset_x_r;
            live_offset_y     <= offset_y_r;
            live_clip         <= clip_r;
            live_transparency <= transparency_r;
            live_freeze       <= freeze_r;
        end
    end

endmodule

// File: rtl/pipeline_spi_layer_control.sv
// SPI command decoder driving per-layer shadow/live overlay controls, global chroma key and image passthrough.
module pipeline_spi_layer_control
    import pipeline_spi_layer_control_pkg::*;
#(
    parameter int PRECISION              = 11,
    parameter int NUM_LAYERS             = 2,
    parameter int TRANSPARENCY_PRECISION = 3,
    parameter int PIXEL_SIZE             = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         spi_active,
    input  logic [7:0]                                   byte_in,
    input  logic                                         byte_valid,
    input  logic                                         frame_start,
    output logic [2*NUM_LAYERS-1:0]                      ctrl_overlay_mode,
    output logic [2*NUM_LAYERS-1:0]                      ctrl_fg_scale,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_x,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_y,
    output logic [4*PRECISION*NUM_LAYERS-1:0]            ctrl_fg_clip,
    output logic [TRANSPARENCY_PRECISION*NUM_LAYERS-1:0] ctrl_fg_transparency,
    output logic [NUM_LAYERS-1:0]                        ctrl_fg_freeze,
    output logic [PIXEL_SIZE-1:0]                        ctrl_green_screen_filter,
    output logic [7:0]                                   img_byte,
    output logic                                         img_byte_valid,
    output logic                                         commit_pending,
    output logic                                         cmd_error
);
    localparam int P = PRECISION;
    localparam int T = TRANSPARENCY_PRECISION;

    state_e                state_r, state_s;
    logic [7:0]            op_r;
    logic [3:0]            layer_r;
    logic [15:0]           arg_r;
    logic                  discard_r;
    logic [PIXEL_SIZE-1:0] filter_shadow_r;
    logic                  bad_layer_s, apply_s, layer_wr_s, clear_s, commit_req_s;
    logic                  filter_wr_s, err_s, commit_s;

    assign bad_layer_s = (byte_in >= 8'(NUM_LAYERS));
    assign commit_s    = frame_start && commit_pending;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // next state: dropping slave-select abandons any command or upload in progress
    always_comb begin
        state_s = state_r;
        if (!spi_active) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (byte_valid) begin
                        if (is_layer_op(byte_in))                               state_s = ST_LAYER;
                        else if ((byte_in == OP_RESET) || (byte_in == OP_COMMIT)) state_s = ST_APPLY;
                        else if (byte_in == OP_FILTER)                          state_s = ST_ARG1;
                        else if (byte_in == OP_IMAGE)                           state_s = ST_PASSTHRU;
                        else                                                    state_s = ST_IDLE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LAYER: if (byte_valid) state_s = ST_ARG1; else state_s = ST_LAYER;
                ST_ARG1: begin
                    if (byte_valid) state_s = (arg_count(op_r) == 2'd2) ? ST_ARG2 : ST_APPLY;
                    else            state_s = ST_ARG1;
                end
                ST_ARG2:     if (byte_valid) state_s = ST_APPLY; else state_s = ST_ARG2;
                ST_APPLY:    state_s = ST_IDLE;
                ST_PASSTHRU: state_s = ST_PASSTHRU;
                default:     state_s = ST_IDLE;
            endcase
        end
    end

    // decoded actions for the current state
    always_comb begin
        apply_s      = (state_r == ST_APPLY) && spi_active && !discard_r;
        layer_wr_s   = apply_s && is_layer_op(op_r);
        clear_s      = apply_s && (op_r == OP_RESET);
        commit_req_s = apply_s && (op_r == OP_COMMIT);
        filter_wr_s  = apply_s && (op_r == OP_FILTER);
        if (spi_active && byte_valid) begin
            if (state_r == ST_IDLE)       err_s = !is_known_op(byte_in);
            else if (state_r == ST_LAYER) err_s = bad_layer_s;
            else                          err_s = 1'b0;
        end else begin
            err_s = 1'b0;
        end
    end

    // command capture: opcode, layer index and big-endian argument shift
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= OP_NOP;
            layer_r   <= 4'd0;
            arg_r     <= 16'd0;
            discard_r <= 1'b0;
        end else if (spi_active && byte_valid) begin
            case (state_r)
                ST_IDLE: begin
                    op_r      <= byte_in;
                    arg_r     <= 16'd0;
                    discard_r <= 1'b0;
                end
                ST_LAYER: begin
                    layer_r   <= byte_in[3:0];
                    discard_r <= bad_layer_s;
                end
                ST_ARG1, ST_ARG2: arg_r <= {arg_r[7:0], byte_in};
                default: ;
            endcase
        end
    end

    // commit handshake and sticky error; a new request outranks a same-cycle commit
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_pending <= 1'b0;
            cmd_error      <= 1'b0;
        end else begin
            if (commit_req_s || clear_s) commit_pending <= 1'b1;
            else if (commit_s)           commit_pending <= 1'b0;
            if (clear_s)     cmd_error <= 1'b0;
            else if (err_s)  cmd_error <= 1'b1;
        end
    end

    // global chroma key, shadowed like the per-layer fields
    always_ff @(posedge clk) begin
        if (rst) begin
            filter_shadow_r          <= PIXEL_SIZE'(FILTER_RESET);
            ctrl_green_screen_filter <= PIXEL_SIZE'(FILTER_RESET);
        end else begin
            if (clear_s)          filter_shadow_r <= PIXEL_SIZE'(FILTER_RESET);
            else if (filter_wr_s) filter_shadow_r <= arg_r[PIXEL_SIZE-1:0];
            if (commit_s) ctrl_green_screen_filter <= filter_shadow_r;
        end
    end

    // image upload forwarding
    always_ff @(posedge clk) begin
        if (rst) begin
            img_byte       <= 8'd0;
            img_byte_valid <= 1'b0;
        end else begin
            img_byte_valid <= (state_r == ST_PASSTHRU) && spi_active && byte_valid;
            if ((state_r == ST_PASSTHRU) && spi_active && byte_valid) img_byte <= byte_in;
        end
    end

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        pipeline_spi_layer_control_regs #(
            .PRECISION              (P),
            .TRANSPARENCY_PRECISION (T)
        ) u_regs (
            .clk               (clk),
            .rst               (rst),
            .wr_en             (layer_wr_s && (layer_r == 4'(k))),
            .wr_op             (op_r),
            .wr_data           (arg_r),
            .clear             (clear_s),
            .commit            (commit_s),
            .live_mode         (ctrl_overlay_mode[2*k +: 2]),
            .live_scale        (ctrl_fg_scale[2*k +: 2]),
            .live_offset_x     (ctrl_fg_offset_x[(P+1)*k +: P+1]),
            .live_offset_y     (ctrl_fg_offset_y[(P+1)*k +: P+1]),
            .live_clip         (ctrl_fg_clip[4*P*k +: 4*P]),
            .live_transparency (ctrl_fg_transparency[T*k +: T]),
            .live_freeze       (ctrl_fg_freeze[k])
        );
    end

endmodule
